subsurf_seq: RTL and testbench

Top-level sequencer for the subdivision-surface datapath. It runs the processing stages (neighbor build, face-point, edge-point, vertex-point) in order through their start/busy handshakes, repeats the whole pass for a programmed number of subdivision iterations, and owns the single port of the 512x32 object RAM. That port goes to the currently running stage, or to the host port when the sequencer is idle. A watchdog flags any stage that fails to handshake or finish.

---
 rtl/subsurf_seq_if.sv | 31 +++
 rtl/subsurf_seq.sv | 108 ++++++++++
 tb/tb_subsurf_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/subsurf_seq_if.sv
// subsurf_seq_if: stage start/busy handshake, per-stage and host object-RAM requests,
// and the single muxed object-RAM port.
interface subsurf_seq_if #(
    parameter int NUM_STAGES = 4
);
    logic [NUM_STAGES-1:0]    stage_start;
    logic [NUM_STAGES-1:0]    stage_busy;
    logic [NUM_STAGES-1:0]    stage_obj_en;
    logic [4*NUM_STAGES-1:0]  stage_obj_we;
    logic [9*NUM_STAGES-1:0]  stage_obj_a;
    logic [32*NUM_STAGES-1:0] stage_obj_di;
    logic                     host_en;
    logic [3:0]               host_we;
    logic [8:0]               host_a;
    logic [31:0]              host_di;
    logic                     RAM_OBJ_EN;
    logic [3:0]               RAM_OBJ_WE;
    logic [8:0]               RAM_OBJ_A;
    logic [31:0]              RAM_OBJ_Di;

    modport master (
        output stage_start, RAM_OBJ_EN, RAM_OBJ_WE, RAM_OBJ_A, RAM_OBJ_Di,
        input  stage_busy, stage_obj_en, stage_obj_we, stage_obj_a, stage_obj_di,
        input  host_en, host_we, host_a, host_di
    );
    modport slave (
        input  stage_start, RAM_OBJ_EN, RAM_OBJ_WE, RAM_OBJ_A, RAM_OBJ_Di,
        output stage_busy, stage_obj_en, stage_obj_we, stage_obj_a, stage_obj_di,
        output host_en, host_we, host_a, host_di
    );
endinterface

// File: rtl/subsurf_seq.sv
// subsurf_seq: runs the subdivision stages in order for a programmed number of passes,
// owns the object RAM port and flags any stage that stalls its start/busy handshake.
module subsurf_seq #(
    parameter int NUM_STAGES = 4,
    parameter int TIMEOUT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          abort,
    input  logic [2:0]    iterations,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    cur_stage,
    output logic [2:0]    cur_iter,
    subsurf_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, ARM, RUN, NEXT, DONE, ERROR} state_t;

    state_t               state_q, state_d;
    logic [1:0]           stage_q, stage_d;
    logic [2:0]           iter_q, iter_d, iters_q, iters_d;
    logic                 err_q, err_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 cur_busy, last_stage, grant;
    int                   sel;

    assign sel        = int'(stage_q);
    assign cur_busy   = bus.stage_busy[stage_q];
    assign last_stage = sel == NUM_STAGES - 1;
    assign err        = err_q;
    assign cur_stage  = stage_q;
    assign cur_iter   = iter_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            iter_q  <= '0;
            iters_q <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            iter_q  <= iter_d;
            iters_q <= iters_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    // abort freezes every register except the state, which drops to IDLE
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        iter_d  = iter_q;
        iters_d = iters_q;
        err_d   = err_q;
        wd_d    = wd_q;
        if (abort) state_d = IDLE;
        else begin
            case (state_q)
                IDLE, ERROR: if (go) begin
                    iters_d = iterations;
                    iter_d  = '0;
                    stage_d = '0;
                    err_d   = 1'b0;
                    state_d = (iterations == 3'd0) ? DONE : START;
                end
                START: begin
                    wd_d    = '0;
                    state_d = ARM;
                end
                ARM, RUN: begin
                    wd_d = wd_q + 1'b1;
                    if (&wd_d) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else if (state_q == ARM && cur_busy) state_d = RUN;
                    else if (state_q == RUN && !cur_busy) state_d = NEXT;
                end
                NEXT: if (!last_stage) begin
                    stage_d = stage_q + 1'b1;
                    state_d = START;
                end else begin
                    stage_d = '0;
                    iter_d  = iter_q + 1'b1;
                    state_d = (iter_d == iters_q) ? DONE : START;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.stage_start = '0;
        if (state_q == START) bus.stage_start[stage_q] = 1'b1;
        busy           = state_q != IDLE && state_q != ERROR;
        done           = state_q == DONE;
        grant          = state_q inside {START, ARM, RUN, NEXT};
        bus.RAM_OBJ_EN = grant ? bus.stage_obj_en[stage_q] : bus.host_en;
        bus.RAM_OBJ_WE = grant ? bus.stage_obj_we[sel*4 +: 4] : bus.host_we;
        bus.RAM_OBJ_A  = grant ? bus.stage_obj_a[sel*9 +: 9] : bus.host_a;
        bus.RAM_OBJ_Di = grant ? bus.stage_obj_di[sel*32 +: 32] : bus.host_di;
    end
endmodule

// File: tb/tb_subsurf_seq.sv
// tb_subsurf_seq: directed runs of the sequencer against behavioural stages, a RAM model
// and a schedule model of when each start pulse, done pulse and grant must appear.
module tb_subsurf_seq;
    localparam int NS = 4, TW = 4, B = 5, SEG = B + 3;

    logic       clk = 1'b0, rst = 1'b0, go = 1'b0, abort = 1'b0;
    logic [2:0] iterations = '0;
    logic       busy, done, err;
    logic [1:0] cur_stage;
    logic [2:0] cur_iter;

    subsurf_seq_if #(.NUM_STAGES(NS)) bus ();

    subsurf_seq #(.NUM_STAGES(NS), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .iterations(iterations),
        .busy(busy), .done(done), .err(err), .cur_stage(cur_stage), .cur_iter(cur_iter),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0, errs = 0;
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [8:0] saddr(int i);
        return 9'h100 + 9'(i * 16);
    endfunction
    function automatic logic [31:0] sdi(int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction
    function automatic int idx(logic [NS-1:0] v);
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return -1;
    endfunction

    // stages: busy from the cycle after their start pulse for B cycles, unless dead
    int cnt [NS] = '{default: 0};
    logic [NS-1:0] dead = '0;
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            bus.stage_busy[i] = cnt[i] != 0;
            if (cnt[i] != 0) cnt[i]--;
            if (bus.stage_start[i] === 1'b1 && !dead[i]) cnt[i] = B;
        end
    end

    logic [31:0] mem [512];
    logic [31:0] ram_do;
    always @(posedge clk) begin
        if (bus.RAM_OBJ_EN === 1'b1) begin
            for (int k = 0; k < 4; k++)
                if (bus.RAM_OBJ_WE[k]) mem[bus.RAM_OBJ_A][8*k +: 8] <= bus.RAM_OBJ_Di[8*k +: 8];
            ram_do <= mem[bus.RAM_OBJ_A];
        end
    end

    // schedule model: run accepted at cycle m_g, every stage slot lasts SEG cycles
    bit m_on = 1'b0;
    int m_g = 0, m_n = 0, m_ab = -1;
    int dc, ce, j, es, ei, done_cnt = 0, done_at = 0, bcnt = 0;
    bit ab, run_c, dn;
    int st_q[$], st_c[$];
    always @(posedge clk) begin
        #2;
        if (bus.stage_start !== '0 && !$isunknown(bus.stage_start)) begin
            st_q.push_back(idx(bus.stage_start));
            st_c.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_at = cyc;
        end
        if (busy === 1'b1) bcnt++;
        if (m_on && cyc > m_g) begin
            dc    = m_g + 1 + m_n * NS * SEG;
            ab    = m_ab >= 0 && cyc > m_ab;
            ce    = ab ? m_ab : cyc;
            run_c = !ab && cyc < dc;
            dn    = !ab && cyc == dc;
            if (ce < dc) begin
                j  = (ce - m_g - 1) / SEG;
                es = j % NS;
                ei = j / NS;
            end else begin
                es = 0;
                ei = m_n;
            end
            chk("stage_start", 32'(bus.stage_start),
                (run_c && (cyc - m_g - 1) % SEG == 0) ? 32'(1 << es) : 32'd0);
            chk("busy", 32'(busy), 32'(run_c || dn));
            chk("done", 32'(done), 32'(dn));
            chk("err", 32'(err), 32'd0);
            chk("cur_stage", 32'(cur_stage), 32'(es));
            chk("cur_iter", 32'(cur_iter), 32'(ei));
            chk("ram_a", 32'(bus.RAM_OBJ_A), run_c ? 32'(saddr(es)) : 32'(bus.host_a));
            chk("ram_di", bus.RAM_OBJ_Di, run_c ? sdi(es) : bus.host_di);
        end
    end

    task automatic wait_cyc(int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic to_neg(int c);
        while (cyc < c) @(negedge clk);
    endtask
    task automatic start_run(int n, int ab_off);
        @(negedge clk);
        iterations = 3'(n);
        go         = 1'b1;
        m_g        = cyc;
        m_n        = n;
        m_ab       = ab_off < 0 ? -1 : cyc + ab_off;
        st_q.delete();
        st_c.delete();
        done_cnt = 0;
        bcnt     = 0;
        m_on     = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask
    task automatic end_model(int c);
        wait_cyc(c);
        @(negedge clk);
        m_on = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int g;
    initial begin
        bus.stage_busy = '0;
        bus.host_en = 1'b0;
        bus.host_we = '0;
        bus.host_a  = '0;
        bus.host_di = '0;
        for (int i = 0; i < NS; i++) begin
            bus.stage_obj_en[i]          = 1'b1;
            bus.stage_obj_we[4*i +: 4]   = 4'(i + 1);
            bus.stage_obj_a[9*i +: 9]    = saddr(i);
            bus.stage_obj_di[32*i +: 32] = sdi(i);
        end
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_start", 32'(bus.stage_start), 0);
        chk("rst_stage", 32'(cur_stage), 0);
        chk("rst_iter", 32'(cur_iter), 0);
        chk("rst_ram_en", 32'(bus.RAM_OBJ_EN), 0);
        chk("rst_ram_a", 32'(bus.RAM_OBJ_A), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // one pass: starts 0..3 eight cycles apart, done 33 cycles after go
        start_run(1, -1);
        g = m_g;
        end_model(g + 1 + NS * SEG + 3);
        chk("t1_starts", st_q.size(), 4);
        foreach (st_q[k]) begin
            chk("t1_order", st_q[k], k);
            chk("t1_spacing", st_c[k] - st_c[0], 8 * k);
        end
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_at", done_at - g, 33);
        chk("t1_cur_iter", 32'(cur_iter), 1);

        // two passes with the host hammering 0x1FF: stage addresses only while granted
        bus.host_en = 1'b1;
        bus.host_a  = 9'h1FF;
        start_run(2, -1);
        g = m_g;
        end_model(g + 1 + 2 * NS * SEG + 3);
        chk("t2_starts", st_q.size(), 8);
        foreach (st_q[k]) chk("t2_order", st_q[k], k % NS);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_done_at", done_at - g, 65);
        chk("t2_cur_iter", 32'(cur_iter), 2);
        bus.host_en = 1'b0;
        bus.host_a  = '0;

        // zero passes: straight to DONE, one busy cycle, no starts
        start_run(0, -1);
        g = m_g;
        end_model(g + 5);
        chk("t3_starts", st_q.size(), 0);
        chk("t3_done_at", done_at - g, 1);
        chk("t3_busy_cycles", bcnt, 1);

        // stage 2 never answers: ERROR 15 cycles after its ARM entry at g+18
        dead[2] = 1'b1;
        start_run(1, -1);
        g = m_g;
        to_neg(g + 18);
        m_on = 1'b0;
        wait_cyc(g + 32);
        chk("t4_busy_pre", 32'(busy), 1);
        chk("t4_err_pre", 32'(err), 0);
        wait_cyc(g + 33);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_err", 32'(err), 1);
        chk("t4_stage", 32'(cur_stage), 2);
        chk("t4_done_cnt", done_cnt, 0);
        @(negedge clk);
        bus.host_en = 1'b1;
        bus.host_we = 4'hF;
        bus.host_a  = 9'h010;
        bus.host_di = 32'hDEAD_BEEF;
        #1;
        chk("t4_host_a", 32'(bus.RAM_OBJ_A), 32'h010);
        chk("t4_host_we", 32'(bus.RAM_OBJ_WE), 32'hF);
        @(negedge clk);
        bus.host_we = '0;
        @(negedge clk);
        bus.host_en = 1'b0;
        chk("t4_readback", ram_do, 32'hDEAD_BEEF);
        bus.host_a  = '0;
        bus.host_di = '0;
        dead[2] = 1'b0;
        start_run(1, -1);
        g = m_g;
        end_model(g + 1 + NS * SEG + 3);
        chk("t4_err_cleared", 32'(err), 0);
        chk("t4_rerun_done", done_cnt, 1);

        // abort in stage 1 RUN, with a go while busy that must be ignored
        start_run(2, 12);
        g = m_g;
        to_neg(g + 5);
        iterations = 3'd7;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        to_neg(g + 12);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_busy_after_abort", 32'(busy), 0);
        end_model(g + 25);
        chk("t5_done_cnt", done_cnt, 0);
        chk("t5_starts", st_q.size(), 2);
        chk("t5_stage_held", 32'(cur_stage), 1);

        // go together with abort in IDLE: abort wins, nothing latched
        to_neg(g + 30);
        iterations = 3'd1;
        go    = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        go    = 1'b0;
        abort = 1'b0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_stage_held", 32'(cur_stage), 1);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
